// File: rtl/syn_fifo_pkg.sv
// Shared definitions for the syn_fifo_flags FIFO: size helpers and the
// error-code enum used when classifying overflow/underflow events.
package syn_fifo_pkg;

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  function automatic int count_width(input int addr_width);
    return addr_width + 1;
  endfunction

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_OVF,
    ERR_UDF
  } fifo_err_e;

endpackage

// File: rtl/syn_fifo_mem.sv
// Dual-port FIFO storage: synchronous write, asynchronous read, no reset.
module syn_fifo_mem
  import syn_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port: store the word on an accepted write.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/syn_fifo_flags.sv
// Synchronous FIFO with occupancy count, almost-full/almost-empty
// thresholds, overflow/underflow pulses and a read-data valid strobe.
// Define SYN_FIFO_FWFT_EN for first-word-fall-through output.
module syn_fifo_flags
  import syn_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_cs,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_cs,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);
  localparam int CW    = count_width(ADDR_WIDTH);

  if (AF_THRESH < 1 || AF_THRESH > DEPTH || AE_THRESH < 0 || AE_THRESH >= DEPTH) begin : g_bad_thresh
    $error("syn_fifo_flags: AF_THRESH must be 1..DEPTH and AE_THRESH 0..DEPTH-1");
  end

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]         count_q;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  wr_req;
  logic                  rd_req;
  logic                  wr_acc;
  logic                  rd_acc;

  assign wr_req = wr_cs & wr_en;
  assign rd_req = rd_cs & rd_en;
  assign wr_acc = wr_req & ~full;
  assign rd_acc = rd_req & ~empty;

  assign count        = count_q;
  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CW'(AF_THRESH));
  assign almost_empty = (count_q <= CW'(AE_THRESH));

  syn_fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk  (clk),
    .we   (wr_acc),
    .waddr(wr_ptr),
    .wdata(data_in),
    .raddr(rd_ptr),
    .rdata(mem_rdata)
  );

  // Pointers and occupancy; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (rd_acc) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Error pulses: one cycle per rejected request, decided on pre-edge flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr_req & full;
      underflow <= rd_req & empty;
    end
  end

`ifdef SYN_FIFO_FWFT_EN
  // Head word is always visible; valid whenever the FIFO holds data.
  assign data_out   = mem_rdata;
  assign data_valid = ~empty;
`else
  // Registered read: capture the head on an accepted read, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= rd_acc;
      if (rd_acc) data_out <= mem_rdata;
    end
  end
`endif

endmodule

// File: tb/tb_syn_fifo_flags.sv
// Scoreboard bench for syn_fifo_flags (default parameters).
module tb_syn_fifo_flags;
  import syn_fifo_pkg::*;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_cs = 1'b0, wr_en = 1'b0, rd_cs = 1'b0, rd_en = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic       data_valid, full, empty, almost_full, almost_empty;
  logic [3:0] count;
  logic       overflow, underflow;

  syn_fifo_flags #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(3),
    .AF_THRESH (6),
    .AE_THRESH (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_cs       (wr_cs),
    .wr_en       (wr_en),
    .data_in     (data_in),
    .rd_cs       (rd_cs),
    .rd_en       (rd_en),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cnt;
    logic       valid;
    fifo_err_e  err;
    logic [7:0] dout;
  } status_t;

  status_t    stat_q[$];
  logic [7:0] data_q[$];
  fifo_err_e  err_q[$];
  logic [7:0] ref_q[$];
  logic [7:0] last_dout = '0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus and push the expected response.
  task automatic do_cycle(input logic r, input logic w, input logic [7:0] d, input logic rd);
    status_t    s;
    logic       wacc, racc;
    logic [7:0] head;
    @(negedge clk);
    rst = r; wr_cs = w; wr_en = w; data_in = d; rd_cs = rd; rd_en = rd;
    s.err   = ERR_NONE;
    s.valid = 1'b0;
    if (r) begin
      ref_q.delete();
      last_dout = '0;
    end else begin
      wacc = w && (ref_q.size() < DEPTH);
      racc = rd && (ref_q.size() > 0);
      if (w && !wacc) begin s.err = ERR_OVF; err_q.push_back(ERR_OVF); end
      if (rd && !racc) begin s.err = ERR_UDF; err_q.push_back(ERR_UDF); end
      if (racc) begin
        head = ref_q.pop_front();
`ifndef SYN_FIFO_FWFT_EN
        data_q.push_back(head);
        last_dout = head;
`endif
      end
      if (wacc) ref_q.push_back(d);
`ifdef SYN_FIFO_FWFT_EN
      s.valid = (ref_q.size() > 0);
`else
      s.valid = racc;
`endif
    end
    s.cnt = ref_q.size();
`ifdef SYN_FIFO_FWFT_EN
    s.dout = (ref_q.size() > 0) ? ref_q[0] : 8'h00;
`else
    s.dout = last_dout;
`endif
    stat_q.push_back(s);
  endtask

  task automatic settle();
    @(posedge clk);
    #3;
  endtask

  // Monitor: compare DUT outputs after every edge against queued expectations.
  always @(posedge clk) begin
    status_t   s;
    fifo_err_e e;
    #2;
    if (stat_q.size() > 0) begin
      s = stat_q.pop_front();
      check("count", int'(count), s.cnt);
      check("full", int'(full), int'(s.cnt == DEPTH));
      check("empty", int'(empty), int'(s.cnt == 0));
      check("almost_full", int'(almost_full), int'(s.cnt >= 6));
      check("almost_empty", int'(almost_empty), int'(s.cnt <= 1));
      check("data_valid", int'(data_valid), int'(s.valid));
      check("overflow", int'(overflow), int'(s.err == ERR_OVF));
      check("underflow", int'(underflow), int'(s.err == ERR_UDF));
`ifdef SYN_FIFO_FWFT_EN
      if (s.valid) check("fwft_head", int'(data_out), int'(s.dout));
`else
      if (!data_valid) check("data_hold", int'(data_out), int'(s.dout));
`endif
    end
`ifndef SYN_FIFO_FWFT_EN
    if (data_valid === 1'b1) begin
      if (data_q.size() == 0) check("unexpected_read_data", int'(data_out), -1);
      else check("read_data", int'(data_out), int'(data_q.pop_front()));
    end
`endif
    if (overflow === 1'b1 || underflow === 1'b1) begin
      e = overflow ? ERR_OVF : ERR_UDF;
      if (err_q.size() == 0) check("unexpected_error", int'(e), int'(ERR_NONE));
      else check("error_code", int'(e), int'(err_q.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    do_cycle(1, 0, 8'h00, 0);
    do_cycle(1, 1, 8'hEE, 1);
    settle();
    check("rst_count", int'(count), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_valid", int'(data_valid), 0);
`ifndef SYN_FIFO_FWFT_EN
    check("rst_dout", int'(data_out), 0);
`endif

    // 1: fill with 0x10..0x17, then one overflowing write
    for (int i = 0; i < 8; i++) do_cycle(0, 1, 8'h10 + 8'(i), 0);
    settle();
    check("t1_count8", int'(count), 8);
    check("t1_full", int'(full), 1);
    do_cycle(0, 1, 8'h99, 0);
    settle();
    check("t1_ovf", int'(overflow), 1);
    check("t1_count_stays", int'(count), 8);

    // 2: drain in order, then one underflowing read
    for (int i = 0; i < 8; i++) do_cycle(0, 0, 8'h00, 1);
    do_cycle(0, 0, 8'h00, 1);
    settle();
    check("t2_udf", int'(underflow), 1);
    check("t2_empty", int'(empty), 1);
`ifndef SYN_FIFO_FWFT_EN
    check("t2_hold_last", int'(data_out), 8'h17);
`endif

    // 3: four words, then 20 cycles of simultaneous read+write
    for (int i = 0; i < 4; i++) do_cycle(0, 1, 8'h20 + 8'(i), 0);
    for (int i = 0; i < 20; i++) do_cycle(0, 1, 8'h30 + 8'(i), 1);
    settle();
    check("t3_count4", int'(count), 4);
    for (int i = 0; i < 4; i++) do_cycle(0, 0, 8'h00, 1);

    // 4: full plus simultaneous read and write
    for (int i = 0; i < 8; i++) do_cycle(0, 1, 8'h40 + 8'(i), 0);
    do_cycle(0, 1, 8'h77, 1);
    settle();
    check("t4_ovf", int'(overflow), 1);
    check("t4_count7", int'(count), 7);

    // 5: reset mid-burst at count 5
    do_cycle(0, 0, 8'h00, 1);
    do_cycle(0, 0, 8'h00, 1);
    do_cycle(1, 1, 8'h55, 1);
    settle();
    check("t5_count0", int'(count), 0);
    check("t5_empty", int'(empty), 1);
    check("t5_valid0", int'(data_valid), 0);
    do_cycle(0, 0, 8'h00, 1);
    settle();
    check("t5_no_stale", int'(underflow), 1);

`ifdef SYN_FIFO_FWFT_EN
    // 6: first-word-fall-through
    do_cycle(0, 1, 8'hA5, 0);
    do_cycle(0, 0, 8'h00, 0);
    settle();
    check("t6_head", int'(data_out), 8'hA5);
    check("t6_valid", int'(data_valid), 1);
    do_cycle(0, 0, 8'h00, 1);
    settle();
    check("t6_empty", int'(empty), 1);
`endif

    for (int i = 0; i < 3; i++) do_cycle(0, 0, 8'h00, 0);
    settle();
    settle();
    check("queues_drained", stat_q.size() + data_q.size() + err_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
